// File: rtl/risc_mem_arbiter_pkg.sv
// Shared types and constants for the RISC data-memory arbiter.
package risc_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } mem_arb_state_e;

  // Requester port indices.
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LSU   = 1'b1;

  // Latency counter width; covers MEM_LAT values 1..7.
  localparam int LAT_CNT_W = 3;

  // One-hot strobe for a selected port.
  function automatic logic [1:0] port_onehot(input logic port);
    return (port == PORT_LSU) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/risc_mem_arbiter_if.sv
// Bundle of requester handshake and memory bus signals around the arbiter.
interface risc_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  // Requester side
  logic [1:0]        req;
  logic [1:0]        we;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic [1:0]        gnt;
  logic [1:0]        rvalid;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  // Memory side
  logic              cs;
  logic              rw;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  // Arbiter view.
  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, data_out,
    output gnt, rvalid, rdata, busy, cs, rw, address, data_in
  );

  // Requesters plus memory model view.
  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, data_out,
    input  gnt, rvalid, rdata, busy, cs, rw, address, data_in
  );

  // Passive memory bus monitor.
  modport probe (
    input cs, rw, address, data_in, data_out
  );

endinterface

// File: rtl/risc_mem_arbiter_rr_arb2.sv
// Two-requester round-robin pick: a lone request wins outright, a tie goes
// to the port that was not granted last.
module rr_arb2
  import risc_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       sel,
  output logic       valid
);

  // Combinational pick among the active requests.
  always_comb begin
    valid = |req;
    sel   = PORT_FETCH;
    unique case (req)
      2'b01:   sel = PORT_FETCH;
      2'b10:   sel = PORT_LSU;
      2'b11:   sel = ~last_gnt;
      default: sel = PORT_FETCH;
    endcase
  end

endmodule

// File: rtl/risc_mem_arbiter.sv
// Shares the single RISC data memory between instruction fetch (port 0) and
// the load/store unit (port 1). One access is in flight at a time: a
// registered cs pulse, a fixed read latency, then read data back to the
// winning port.
module risc_mem_arbiter
  import risc_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  risc_mem_arbiter_if.slave bus
);

  // WAIT covers cycles 2..MEM_LAT after the cs cycle; the counter starts at
  // MEM_LAT-1 and RESP follows once it reads 1.
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT - 1);

  mem_arb_state_e        state;
  logic                  last_gnt;
  logic                  sel;
  logic [LAT_CNT_W-1:0]  lat_cnt;
  logic [1:0]            gnt;
  logic [1:0]            rvalid;
  logic                  cs;
  logic                  rw;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W-1:0]     data_in;
  logic [DATA_W-1:0]     rdata;

  logic                  arb_sel;
  logic                  arb_valid;
  logic                  pick_we;
  logic [ADDR_W-1:0]     pick_addr;
  logic [DATA_W-1:0]     pick_wdata;

  rr_arb2 u_arb (
    .req      (bus.req),
    .last_gnt (last_gnt),
    .sel      (arb_sel),
    .valid    (arb_valid)
  );

  // Steer the winning port's command fields toward the memory registers.
  always_comb begin
    pick_we    = bus.we[0];
    pick_addr  = bus.addr0;
    pick_wdata = bus.wdata0;
    if (arb_sel == PORT_LSU) begin
      pick_we    = bus.we[1];
      pick_addr  = bus.addr1;
      pick_wdata = bus.wdata1;
    end
  end

  // Arbiter FSM with registered memory-bus and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= PORT_LSU;
      sel      <= PORT_FETCH;
      lat_cnt  <= '0;
      gnt      <= '0;
      rvalid   <= '0;
      cs       <= 1'b0;
      rw       <= 1'b0;
      address  <= '0;
      data_in  <= '0;
      rdata    <= '0;
    end else begin
      // Strobes last exactly one cycle unless re-asserted below.
      gnt    <= '0;
      rvalid <= '0;
      cs     <= 1'b0;

      unique case (state)
        IDLE: begin
          if (arb_valid) begin
            sel      <= arb_sel;
            last_gnt <= arb_sel;
            gnt      <= port_onehot(arb_sel);
            cs       <= 1'b1;
            rw       <= pick_we;
            address  <= pick_addr;
            data_in  <= pick_wdata;
            state    <= ACCESS;
          end
        end

        ACCESS: begin
          if (rw) begin
            state <= IDLE;
          end else if (MEM_LAT == 1) begin
            state <= RESP;
          end else begin
            lat_cnt <= LAT_LOAD;
            state   <= WAIT;
          end
        end

        WAIT: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LAT_CNT_W'(1)) begin
            state <= RESP;
          end
        end

        RESP: begin
          // Memory data is valid in this cycle only.
          rdata  <= bus.data_out;
          rvalid <= port_onehot(sel);
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt;
  assign bus.rvalid  = rvalid;
  assign bus.rdata   = rdata;
  assign bus.busy    = (state != IDLE);
  assign bus.cs      = cs;
  assign bus.rw      = rw;
  assign bus.address = address;
  assign bus.data_in = data_in;

endmodule

// File: doc/risc_mem_arbiter.md
# risc_mem_arbiter

Two-port memory arbiter that shares the single RISC data memory (cs / rw / address / data_in / data_out) between the instruction-fetch unit (port 0) and the load/store unit (port 1). It accepts one request at a time and arbitrates ties round-robin. It drives a one-cycle registered memory access, waits the fixed memory read latency, and returns read data to the winning requester. It sits in the RISC core between the fetch/LSU stages and the memory model.

## Interface
Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- MEM_LAT, 1, cycles from the cs-asserted cycle to valid data_out (1..7)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req[1:0]  in  2  per-port request; bit 0 = fetch, bit 1 = LSU
- we[1:0]  in  2  per-port write enable (1 = write)
- addr0, addr1  in  ADDR_W  per-port address
- wdata0, wdata1  in  DATA_W  per-port write data
- gnt[1:0]  out  2  one-hot accept pulse, one cycle
- rvalid[1:0]  out  2  one-hot read-data-valid pulse, one cycle
- rdata  out  DATA_W  read data, valid when an rvalid bit is high
- busy  out  1  high whenever state != IDLE
- cs  out  1  memory chip select, active high
- rw  out  1  1 = write, 0 = read (meaningful only with cs)
- address  out  ADDR_W  memory address
- data_in  out  DATA_W  write data to memory
- data_out  in  DATA_W  read data from memory

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: sample req. If neither bit is set, stay. If exactly one bit is set, select that port. If both are set, select the port not granted last (last_gnt pointer). Go to ACCESS and register cs=1, rw=we[sel], address=addr_sel, data_in=wdata_sel, gnt[sel]=1, last_gnt=sel.
- ACCESS (one cycle, cs high):
  - Write: go to IDLE.
  - Read with MEM_LAT=1: go to RESP.
  - Read with MEM_LAT>1: go to WAIT with the latency counter loaded to MEM_LAT-1.
- WAIT: decrement the counter; go to RESP on reaching 1.
- RESP: data_out is valid this cycle. Register rdata=data_out and rvalid[sel]=1 for the next cycle. Go to IDLE.
- cs, gnt and rvalid are cleared on every cycle they are not being set. address, data_in and rdata hold their last value.
- Requests are sampled only in IDLE.
  - A requester holds req/we/addr/wdata stable until it sees gnt. It may drop req before gnt with no effect.
  - It deasserts req, or presents its next request, in the cycle after gnt.
- A new arbitration can occur in the same cycle rvalid is high (that cycle is IDLE).
- The arbiter never issues cs while a read is outstanding.

## Timing
- Reset values: state=IDLE, last_gnt=1 (fetch wins the first tie), gnt=0, rvalid=0, cs=0, rw=0, address=0, data_in=0, rdata=0, busy=0.
- Read, request seen in IDLE at cycle N:
  - gnt and cs high in N+1.
  - data_out sampled in cycle N+1+MEM_LAT.
  - rvalid high in N+2+MEM_LAT.
  - MEM_LAT=1 gives a 3-cycle request-to-data latency.
- Write, request seen at N: gnt and cs high in N+1, IDLE in N+2. Peak rate is one write per 2 cycles.
- rst high in any state:
  - Forces the reset values at the next edge.
  - Any in-flight read is dropped with no rvalid.
  - A cs pulse in progress ends at that edge.
- Simultaneous req from both ports alternates grants strictly: 0,1,0,1 under continuous contention.

## Structure
- Shared package (risc_pkg): mem_arb_state_e enum (IDLE, ACCESS, WAIT, RESP) and port index constants PORT_FETCH=0, PORT_LSU=1.
- One natural sub-module: rr_arb2, a combinational two-requester round-robin pick (inputs req[1:0] and last_gnt, output sel and valid). Everything else lives in risc_mem_arbiter.
- The probe interface monitors cs/rw/address/data_in/data_out unchanged.

## Test plan
- Single read, MEM_LAT=1: port0 req addr=0x10, memory holds 0xA5 → gnt[0] in cycle 1, cs=1/rw=0/address=0x10 in cycle 1, rvalid[0]=1 with rdata=0xA5 in cycle 3, busy low after.
- Single write: port1 req we=1 addr=0x20 wdata=0x3C → gnt[1] and cs=1/rw=1/data_in=0x3C for exactly one cycle; a following read of 0x20 returns 0x3C.
- Contention: both ports request continuously after reset (reads, 0x01 and 0x02) → grant order 0,1,0,1; rvalid one-hot matches each grant; never two cs pulses without an intervening rvalid.
- Latency parameter: MEM_LAT=3, port0 read → cs in cycle 1, rvalid in cycle 5, busy high in cycles 1–4.
- Reset mid-read: assert rst in WAIT → next cycle all outputs at reset values, no rvalid ever appears for that read, and the next post-reset tie grants port0.
- Request withdrawn: port1 raises req while busy and drops it before IDLE → no gnt[1], no cs for addr1.
